// File: rtl/shift_merge_pipe_if.sv
// Request/response bundle for shift_merge_pipe: valid/ready request side
// with field controls and operands, valid/ready result side.
interface shift_merge_pipe_if #(
    parameter int WIDTH = 32,
    parameter int LW    = $clog2(WIDTH)
);
    logic             inValid;
    logic             inReady;
    logic [1:0]       op;
    logic             modeBit;
    logic             useSa;
    logic [LW-1:0]    posIn;
    logic [LW-1:0]    lenIn;
    logic [WIDTH-1:0] saReg;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] result;
    logic             fieldErr;

    modport master (
        output inValid, op, modeBit, useSa, posIn, lenIn,
        output saReg, a, b, outReady,
        input  inReady, outValid, result, fieldErr
    );

    modport slave (
        input  inValid, op, modeBit, useSa, posIn, lenIn,
        input  saReg, a, b, outReady,
        output inReady, outValid, result, fieldErr
    );
endinterface

// File: rtl/shift_merge_pipe.sv
// Two-stage extract / deposit / double-shift-right unit, big-endian bit numbering.
// Define SHIFT_MERGE_FIELD_CHK_EN to flag EXTR/DEP fields that cross bit 0.
module shift_merge_pipe #(
    parameter int WIDTH = 32,
    parameter int LW    = $clog2(WIDTH)
) (
    input logic               clk,
    input logic               rstN,
    shift_merge_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        OP_EXTR = 2'd0,
        OP_DEP  = 2'd1,
        OP_DSR  = 2'd2,
        OP_RSV  = 2'd3
    } op_e;

    typedef struct packed {
        op_e              op;
        logic             modeBit;
        logic [LW-1:0]    pl;
        logic [LW-1:0]    pr;
        logic             err;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic             live_q, live_d;
    logic             s1_valid_q, s1_valid_d;
    s1_t              s1_q, s1_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             field_err_q, field_err_d;

    logic             adv1, adv2, in_ready, accept;
    logic [LW-1:0]    sa, pl_new;
    logic             clamp, err_new;
    logic             unusedSaHi;

    assign unusedSaHi = ^bus.saReg[WIDTH-1:LW];

    // Stage 1 decode: shift amount, clamped field ends
    always_comb begin
        sa     = bus.useSa ? bus.saReg[LW-1:0] : bus.posIn;
        clamp  = bus.lenIn > sa;
        pl_new = clamp ? '0 : sa - bus.lenIn;
`ifdef SHIFT_MERGE_FIELD_CHK_EN
        err_new = clamp &&
                  (bus.op == OP_EXTR || bus.op == OP_DEP);
`else
        err_new = 1'b0;
`endif
    end

    // A stage may advance whenever the one after it is empty or draining
    assign adv2     = !s2_valid_q || bus.outReady;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = live_q && adv1;
    assign accept   = bus.inValid && in_ready;

    always_comb begin
        live_d     = 1'b1;
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        if (adv1) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_d.op      = op_e'(bus.op);
            s1_d.modeBit = bus.modeBit;
            s1_d.pl      = pl_new;
            s1_d.pr      = sa;
            s1_d.err     = err_new;
            s1_d.a       = bus.a;
            s1_d.b       = bus.b;
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
        end
    end

    logic [LW-1:0]      s2_shift, s2_msh;
    logic [WIDTH-1:0]   low_mask, fld_mask, top_bit;
    logic [WIDTH-1:0]   ext, extr_res, dep_res, dsr_res, bg;
    logic [2*WIDTH-1:0] cat;
    logic               sgn;
    logic [WIDTH-1:0]   calc_res;
    logic               calc_err;

    // Big-endian position pr maps to little-endian bit WIDTH-1-pr, i.e. ~pr
    always_comb begin
        s2_shift = ~s1_q.pr;
        s2_msh   = s2_shift + s1_q.pl;
        low_mask = ONES >> s2_msh;
        fld_mask = low_mask << s2_shift;
        top_bit  = low_mask ^ (low_mask >> 1);

        ext      = (s1_q.a >> s2_shift) & low_mask;
        sgn      = |(ext & top_bit);
        extr_res = (s1_q.modeBit && sgn) ? (ext | ~low_mask) : ext;

        bg       = s1_q.modeBit ? '0 : s1_q.a;
        dep_res  = (bg & ~fld_mask) |
                   ((s1_q.b << s2_shift) & fld_mask);

        cat      = {s1_q.a, s1_q.b} >> s1_q.pr;
        dsr_res  = cat[WIDTH-1:0];

        calc_res = '0;
        calc_err = 1'b0;
        unique case (s1_q.op)
            OP_EXTR: begin
                calc_res = extr_res;
                calc_err = s1_q.err;
            end
            OP_DEP: begin
                calc_res = dep_res;
                calc_err = s1_q.err;
            end
            OP_DSR: begin
                calc_res = dsr_res;
            end
            default: begin
                calc_res = '0;
                calc_err = 1'b0;
            end
        endcase
    end

    always_comb begin
        result_d    = result_q;
        field_err_d = field_err_q;
        if (adv2 && s1_valid_q) begin
            result_d    = calc_res;
            field_err_d = calc_err;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            live_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            s2_valid_q  <= 1'b0;
            result_q    <= '0;
            field_err_q <= 1'b0;
        end else begin
            live_q      <= live_d;
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            s2_valid_q  <= s2_valid_d;
            result_q    <= result_d;
            field_err_q <= field_err_d;
        end
    end

    assign bus.inReady  = in_ready;
    assign bus.outValid = s2_valid_q;
    assign bus.result   = result_q;
    assign bus.fieldErr = field_err_q;

endmodule

// File: tb/tb_shift_merge_pipe.sv
// Directed bench for shift_merge_pipe (WIDTH=32): field ops, clamp,
// backpressure ordering and mid-flight reset.
module tb_shift_merge_pipe;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   checks = 0;
    int   errors = 0;

    shift_merge_pipe_if #(.WIDTH(32)) bus ();

    shift_merge_pipe #(.WIDTH(32)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not terminate");
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request through an idle pipe: check accept, latency and result
    task automatic req(input string tag,
                       input logic [1:0] op, input logic mode,
                       input logic use_sa, input logic [4:0] pos,
                       input logic [4:0] len, input logic [31:0] sa,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic exp_e);
        bus.op       = op;
        bus.modeBit  = mode;
        bus.useSa    = use_sa;
        bus.posIn    = pos;
        bus.lenIn    = len;
        bus.saReg    = sa;
        bus.a        = a;
        bus.b        = b;
        bus.outReady = 1'b1;
        bus.inValid  = 1'b1;
        @(negedge clk);
        chk({tag, "_inReady"}, 64'(bus.inReady), 64'd1);
        @(posedge clk); #1;
        bus.inValid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_outValid"}, 64'(bus.outValid), 64'd1);
        chk({tag, "_result"}, 64'(bus.result), 64'(exp_r));
        chk({tag, "_fieldErr"}, 64'(bus.fieldErr), 64'(exp_e));
        @(posedge clk); #1;
    endtask

    logic exp_clamp_err;
    int   acc, got, stale;

    initial begin
`ifdef SHIFT_MERGE_FIELD_CHK_EN
        exp_clamp_err = 1'b1;
`else
        exp_clamp_err = 1'b0;
`endif
        bus.inValid  = 1'b0;
        bus.op       = 2'd0;
        bus.modeBit  = 1'b0;
        bus.useSa    = 1'b0;
        bus.posIn    = '0;
        bus.lenIn    = '0;
        bus.saReg    = '0;
        bus.a        = '0;
        bus.b        = '0;
        bus.outReady = 1'b1;

        #12;
        chk("rst_inReady", 64'(bus.inReady), 64'd0);
        chk("rst_outValid", 64'(bus.outValid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_fieldErr", 64'(bus.fieldErr), 64'd0);
        #6 rstN = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_inReady", 64'(bus.inReady), 64'd1);

        req("extr_zx", 2'd0, 1'b0, 1'b0, 5'd19, 5'd9, 32'd0,
            32'h003FF000, 32'd0, 32'h000003FF, 1'b0);
        req("extr_sx", 2'd0, 1'b1, 1'b0, 5'd19, 5'd9, 32'd0,
            32'h003FF000, 32'd0, 32'hFFFFFFFF, 1'b0);
        req("dsr_sa8", 2'd2, 1'b0, 1'b1, 5'd0, 5'd0, 32'd8,
            32'h12345678, 32'h9ABCDEF0, 32'h789ABCDE, 1'b0);
        req("dsr_sa0", 2'd2, 1'b0, 1'b1, 5'd17, 5'd0, 32'hFFFFFF00,
            32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 1'b0);
        req("dsr_pos16", 2'd2, 1'b0, 1'b0, 5'd16, 5'd3, 32'd5,
            32'h12345678, 32'h9ABCDEF0, 32'h56789ABC, 1'b0);
        req("dep_merge", 2'd1, 1'b0, 1'b0, 5'd31, 5'd7, 32'd0,
            32'hFFFFFFFF, 32'h00000000, 32'hFFFFFF00, 1'b0);
        req("dep_zero", 2'd1, 1'b1, 1'b0, 5'd31, 5'd7, 32'd0,
            32'hFFFFFFFF, 32'h000000AB, 32'h000000AB, 1'b0);
        req("dep_mid", 2'd1, 1'b0, 1'b0, 5'd15, 5'd3, 32'd0,
            32'h00000000, 32'hFFFFFFF5, 32'h00050000, 1'b0);
        req("extr_clamp", 2'd0, 1'b0, 1'b0, 5'd3, 5'd9, 32'd0,
            32'hF0000000, 32'd0, 32'h0000000F, exp_clamp_err);
        req("rsv_op", 2'd3, 1'b1, 1'b0, 5'd3, 5'd9, 32'd0,
            32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);

        // Four back-to-back DSR-by-0 requests, result = B, consumer stalled 3 cycles
        acc = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            bus.op       = 2'd2;
            bus.useSa    = 1'b0;
            bus.posIn    = '0;
            bus.lenIn    = '0;
            bus.a        = 32'hDEADBEEF;
            bus.b        = 32'h100 + 32'(acc);
            bus.inValid  = (acc < 4);
            bus.outReady = (cyc >= 3);
            @(negedge clk);
            if (cyc == 2) begin
                chk("bp_inReady_low", 64'(bus.inReady), 64'd0);
                chk("bp_hold_valid", 64'(bus.outValid), 64'd1);
                chk("bp_hold_result", 64'(bus.result), 64'h100);
            end
            if (bus.outValid && bus.outReady) begin
                chk("bp_order", 64'(bus.result), 64'(32'h100 + 32'(got)));
                got++;
            end
            if (bus.inValid && bus.inReady) acc++;
            @(posedge clk); #1;
        end
        bus.inValid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd4);
        chk("bp_results", 64'(got), 64'd4);

        // Two requests in flight, then an asynchronous reset pulse
        bus.outReady = 1'b1;
        bus.b        = 32'h55;
        bus.inValid  = 1'b1;
        @(posedge clk); #1;
        bus.b = 32'h66;
        @(posedge clk); #1;
        bus.inValid = 1'b0;
        chk("flight_outValid", 64'(bus.outValid), 64'd1);
        rstN = 1'b0;
        #1;
        chk("mid_rst_outValid", 64'(bus.outValid), 64'd0);
        chk("mid_rst_inReady", 64'(bus.inReady), 64'd0);
        chk("mid_rst_result", 64'(bus.result), 64'd0);
        #1 rstN = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.outValid) stale++;
        end
        chk("no_stale", 64'(stale), 64'd0);
        @(posedge clk); #1;

        req("post_rst_extr", 2'd0, 1'b0, 1'b1, 5'd0, 5'd3, 32'd7,
            32'h0F000000, 32'd0, 32'h0000000F, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_merge_pipe.md
SHIFT_MERGE_PIPE -- requirements
Module: shift_merge_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; power of two, 8..64.
REQ-002 Parameter LW, default $clog2(WIDTH), width of the position, length and shift fields.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstN  input  1  asynchronous active-low reset; assertion clears all state immediately, release is synchronous to clk.
REQ-005 inValid  input  1  request present this cycle.
REQ-006 inReady  output  1  block accepts the request this cycle.
REQ-007 op  input  2  operation: 0 EXTR, 1 DEP, 2 DSR, 3 reserved.
REQ-008 modeBit  input  1  EXTR: 1 = sign-extend, 0 = zero-extend; DEP: 1 = zero background, 0 = merge into A; DSR: ignored.
REQ-009 useSa  input  1  1 = take position/shift from saReg, 0 = take it from posIn.
REQ-010 posIn  input  LW  field right-end bit position (EXTR/DEP) or shift amount (DSR).
REQ-011 lenIn  input  LW  field length minus one (1..WIDTH bits).
REQ-012 saReg  input  WIDTH  shift-amount register; only its low LW bits are used.
REQ-013 a, b  input  WIDTH each  operands A and B.
REQ-014 outValid  output  1  result present.
REQ-015 outReady  input  1  consumer takes the result this cycle.
REQ-016 result  output  WIDTH  operation result.
REQ-017 fieldErr  output  1  field crosses bit 0; qualified by outValid.

Function
REQ-018 Bit numbering is big-endian: bit 0 = MSB, bit WIDTH-1 = LSB.
REQ-019 Stage 1 registers the decoded controls: shamt sa = useSa ? saReg[low LW] : posIn; left position pl = sa - lenIn; right position pr = sa.
REQ-020 Stage 2 computes result from the stage-1 registers and holds it in an output register.
REQ-021 EXTR: bits pl..pr of A, right-justified, extended per modeBit.
REQ-022 DEP: the low lenIn+1 bits of B replace bits pl..pr of a background, which is A (modeBit=0) or zero (modeBit=1).
REQ-023 DSR: result = low WIDTH bits of the 2*WIDTH value {A,B} shifted right logically by sa; sa=0 returns B.
REQ-024 Reserved op: result = 0, fieldErr = 0; the pipeline still advances.
REQ-025 Field clamp: when lenIn > pr, pl clamps to 0 and the field is bits 0..pr.
REQ-026 Handshake: a request transfers when inValid & inReady; a result transfers when outValid & outReady.
REQ-027 Latency: exactly 2 clk cycles from input transfer to outValid; throughput 1 per cycle.
REQ-028 Backpressure: while outValid & !outReady, both stages hold, and inReady = !stage1Valid.
REQ-029 A bubble in stage 2 is filled while stage 1 is held only when stage 2 is empty; no request is lost or duplicated.
REQ-030 inReady is combinational from stage occupancy and outReady only, never from inValid.
REQ-031 result and fieldErr stay stable while outValid & !outReady.

Reset
REQ-032 While rstN=0: stage valids = 0, inReady = 0, outValid = 0, result = 0, fieldErr = 0.
REQ-033 Reset asserted mid-operation discards all in-flight requests; there is no partial output.
REQ-034 inReady = 1 on the first clk edge after rstN deasserts.

Configuration
REQ-035 Macro SHIFT_MERGE_FIELD_CHK_EN defined: fieldErr = 1 for EXTR/DEP when lenIn > pr (clamp per REQ-025 still applied).
REQ-036 Macro SHIFT_MERGE_FIELD_CHK_EN undefined: fieldErr is tied to 0 and no check logic is built; result behaviour is identical.

Verification (WIDTH=32)
REQ-037 EXTR, posIn=19, lenIn=9, modeBit=0, A=0x003FF000 -> result 0x000003FF, 2 cycles after transfer; with modeBit=1 -> 0xFFFFFFFF.
REQ-038 DSR, useSa=1, saReg=8, A=0x12345678, B=0x9ABCDEF0 -> 0x789ABCDE; with saReg=0 -> 0x9ABCDEF0.
REQ-039 DEP, posIn=31, lenIn=7, A=0xFFFFFFFF, B=0 -> 0xFFFFFF00; with modeBit=1, B=0xAB -> 0x000000AB.
REQ-040 EXTR posIn=3, lenIn=9, A=0xF0000000 -> result 0x0000000F; fieldErr=1 with the macro, 0 without.
REQ-041 Back-to-back 4 requests with outReady held low 3 cycles -> inReady drops after 2 accepts; all 4 results emerge in order with none lost.
REQ-042 rstN pulsed low with 2 requests in flight -> outValid=0 immediately; no stale result appears after release.
